// File: rtl/dcache_if.sv
// Processor data-port and backing-memory bus for the direct-mapped data cache.
// The slave modport is the cache; the master modport is its environment.
interface dcache_if;
    logic        Mem_re;
    logic        Mem_we;
    logic [15:0] d_addr;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        d_hit;
    logic        mem_req;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;

    modport slave (
        input  Mem_re, Mem_we, d_addr, wrt_data, mem_rdata, mem_rdy,
        output rd_data, d_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output Mem_re, Mem_we, d_addr, wrt_data, mem_rdata, mem_rdy,
        input  rd_data, d_hit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with combinational hit path
// and a WB/FILL line transfer sequence to 64-bit backing memory.
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic    clk,
    input  logic    rst,
    dcache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2} state_t;

    state_t                  state_r;
    logic [LINES-1:0]        valid_r;
    logic [LINES-1:0]        dirty_r;
    logic [63:0]             data_mem_r [LINES];
    logic [TAG_W-1:0]        tag_mem_r  [LINES];
    logic [13:0]             miss_addr_r;

    logic [INDEX_BITS-1:0]   idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [1:0]              off_s;
    logic [INDEX_BITS-1:0]   miss_idx_s;
    logic [TAG_W-1:0]        miss_tag_s;
    logic                    req_s;
    logic                    hit_s;
    logic [63:0]             line_s;

    assign idx_s      = bus.d_addr[INDEX_BITS+1:2];
    assign tag_s      = bus.d_addr[15:INDEX_BITS+2];
    assign off_s      = bus.d_addr[1:0];
    assign miss_idx_s = miss_addr_r[INDEX_BITS-1:0];
    assign miss_tag_s = miss_addr_r[13:INDEX_BITS];
    assign req_s      = bus.Mem_re | bus.Mem_we;
    assign hit_s      = valid_r[idx_s] & (tag_mem_r[idx_s] == tag_s);
    assign line_s     = data_mem_r[idx_s];
    assign bus.d_hit  = (state_r == IDLE) & req_s & hit_s;

    // Read word select from the indexed line.
    always_comb begin
        bus.rd_data = 16'h0000;
        case (off_s)
            2'd0:    bus.rd_data = line_s[15:0];
            2'd1:    bus.rd_data = line_s[31:16];
            2'd2:    bus.rd_data = line_s[47:32];
            2'd3:    bus.rd_data = line_s[63:48];
            default: bus.rd_data = 16'h0000;
        endcase
    end

    // Control FSM: state, valid/dirty bits, miss address and registered memory-bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            valid_r       <= '0;
            dirty_r       <= '0;
            miss_addr_r   <= 14'h0000;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 14'h0000;
            bus.mem_wdata <= 64'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        if (bus.Mem_we) begin
                            dirty_r[idx_s] <= 1'b1;
                        end
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= 14'h0000;
                        bus.mem_wdata <= 64'h0;
                    end else if (req_s) begin
                        miss_addr_r <= bus.d_addr[15:2];
                        bus.mem_req <= 1'b1;
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_r       <= WB;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= {tag_mem_r[idx_s], idx_s};
                            bus.mem_wdata <= line_s;
                        end else begin
                            state_r       <= FILL;
                            bus.mem_we    <= 1'b0;
                            bus.mem_addr  <= bus.d_addr[15:2];
                            bus.mem_wdata <= 64'h0;
                        end
                    end else begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= 14'h0000;
                        bus.mem_wdata <= 64'h0;
                    end
                end
                WB: begin
                    if (bus.mem_rdy) begin
                        dirty_r[miss_idx_s] <= 1'b0;
                        state_r             <= FILL;
                        bus.mem_we          <= 1'b0;
                        bus.mem_addr        <= miss_addr_r;
                        bus.mem_wdata       <= 64'h0;
                    end else begin
                        state_r <= WB;
                    end
                end
                FILL: begin
                    if (bus.mem_rdy) begin
                        valid_r[miss_idx_s] <= 1'b1;
                        dirty_r[miss_idx_s] <= 1'b0;
                        state_r             <= IDLE;
                        bus.mem_req         <= 1'b0;
                        bus.mem_we          <= 1'b0;
                        bus.mem_addr        <= 14'h0000;
                        bus.mem_wdata       <= 64'h0;
                    end else begin
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    bus.mem_req   <= 1'b0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_addr  <= 14'h0000;
                    bus.mem_wdata <= 64'h0;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity is tracked by valid_r alone.
    always_ff @(posedge clk) begin
        if (state_r == FILL && bus.mem_rdy) begin
            data_mem_r[miss_idx_s] <= bus.mem_rdata;
            tag_mem_r[miss_idx_s]  <= miss_tag_s;
        end else if (bus.d_hit && bus.Mem_we) begin
            data_mem_r[idx_s][{off_s, 4'b0000} +: 16] <= bus.wrt_data;
        end else begin
            data_mem_r[idx_s] <= data_mem_r[idx_s];
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: cold miss, write hit, dirty eviction,
// zero-wait latency, reset during fill and withdrawn requests.
module tb_dcache_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dcache_if bus();

    dcache_ctrl #(.INDEX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Mem_re = 1'b0; bus.Mem_we = 1'b0; bus.d_addr = 16'h0000; bus.wrt_data = 16'h0000;
        bus.mem_rdata = 64'h0; bus.mem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 81'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got hit=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                     bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cold_read();
        bus.Mem_re = 1'b1; bus.d_addr = 16'h0106;
        #1;
        vectors++;
        if (bus.d_hit !== 1'b0) begin
            miscompares++; $display("FAIL cold_no_hit: got d_hit=%b expected 0", bus.d_hit);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b0, 1'b1, 1'b0, 14'h0041}) begin
                miscompares++;
                $display("FAIL cold_fill_req[%0d]: got hit=%b req=%b we=%b addr=%h expected 0/1/0/0041",
                         i, bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr);
            end
            if (i < 3) tick();
        end
        bus.mem_rdata = 64'h4444_3333_2222_1111; bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        #1;
        vectors++;
        if ({bus.d_hit, bus.rd_data, bus.mem_req} !== {1'b1, 16'h3333, 1'b0}) begin
            miscompares++;
            $display("FAIL cold_hit: got hit=%b rd=%h req=%b expected 1/3333/0",
                     bus.d_hit, bus.rd_data, bus.mem_req);
        end
    endtask

    task automatic test_write_hit();
        bus.Mem_re = 1'b0; bus.Mem_we = 1'b1; bus.d_addr = 16'h0105; bus.wrt_data = 16'hBEEF;
        #1;
        vectors++;
        if (bus.d_hit !== 1'b1) begin
            miscompares++; $display("FAIL write_hit: got d_hit=%b expected 1", bus.d_hit);
        end
        tick();
        bus.Mem_we = 1'b0; bus.Mem_re = 1'b1;
        #1;
        vectors++;
        if ({bus.d_hit, bus.rd_data, bus.mem_req} !== {1'b1, 16'hBEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL write_readback: got hit=%b rd=%h req=%b expected 1/beef/0",
                     bus.d_hit, bus.rd_data, bus.mem_req);
        end
        tick();
    endtask

    task automatic test_dirty_evict();
        bus.d_addr = 16'h0144;
        #1;
        vectors++;
        if (bus.d_hit !== 1'b0) begin
            miscompares++; $display("FAIL evict_no_hit: got d_hit=%b expected 0", bus.d_hit);
        end
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {1'b1, 1'b1, 14'h0041, 64'h4444_3333_BEEF_1111}) begin
            miscompares++;
            $display("FAIL evict_wb: got req=%b we=%b addr=%h wdata=%h expected 1/1/0041/44443333beef1111",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        vectors++;
        if ({bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b0, 1'b1, 1'b0, 14'h0051}) begin
            miscompares++;
            $display("FAIL evict_fill: got hit=%b req=%b we=%b addr=%h expected 0/1/0/0051",
                     bus.d_hit, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_rdata = 64'h8888_7777_6666_5555; bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        vectors++;
        if ({bus.d_hit, bus.rd_data} !== {1'b1, 16'h5555}) begin
            miscompares++;
            $display("FAIL evict_hit: got hit=%b rd=%h expected 1/5555", bus.d_hit, bus.rd_data);
        end
        bus.d_addr = 16'h0105;
        #1;
        vectors++;
        if (bus.d_hit !== 1'b0) begin
            miscompares++; $display("FAIL evict_old_miss: got d_hit=%b expected 0", bus.d_hit);
        end
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 14'h0041}) begin
            miscompares++;
            $display("FAIL evict_refill_req: got req=%b we=%b addr=%h expected 1/0/0041",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_rdata = 64'h4444_3333_BEEF_1111; bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0; bus.Mem_re = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait();
        bus.mem_rdy = 1'b1; bus.mem_rdata = 64'hAAAA_0003_0002_0001;
        bus.Mem_re = 1'b1; bus.d_addr = 16'h00C8;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.d_hit !== (c == 2)) begin
                miscompares++;
                $display("FAIL clean_latency[c%0d]: got d_hit=%b expected %b", c, bus.d_hit, (c == 2));
            end
            if (c < 2) tick();
        end
        vectors++;
        if (bus.rd_data !== 16'h0001) begin
            miscompares++; $display("FAIL clean_data: got rd=%h expected 0001", bus.rd_data);
        end
        bus.Mem_re = 1'b0; bus.Mem_we = 1'b1; bus.wrt_data = 16'hCAFE;
        tick();
        bus.Mem_we = 1'b0; bus.Mem_re = 1'b1; bus.d_addr = 16'h01C8;
        bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (bus.d_hit !== (c == 3)) begin
                miscompares++;
                $display("FAIL dirty_latency[c%0d]: got d_hit=%b expected %b", c, bus.d_hit, (c == 3));
            end
            if (c == 1) begin
                vectors++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 14'h0032, 64'hAAAA_0003_0002_CAFE}) begin
                    miscompares++;
                    $display("FAIL zw_wb: got we=%b addr=%h wdata=%h expected 1/0032/aaaa00030002cafe",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (c == 2) begin
                vectors++;
                if ({bus.mem_we, bus.mem_addr} !== {1'b0, 14'h0072}) begin
                    miscompares++;
                    $display("FAIL zw_fill: got we=%b addr=%h expected 0/0072", bus.mem_we, bus.mem_addr);
                end
            end
            if (c < 3) tick();
        end
        vectors++;
        if (bus.rd_data !== 16'hDEF0) begin
            miscompares++; $display("FAIL dirty_data: got rd=%h expected def0", bus.rd_data);
        end
        bus.Mem_re = 1'b0; bus.mem_rdy = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fill();
        bus.Mem_re = 1'b1; bus.d_addr = 16'h008C;
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.mem_req, bus.d_hit} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_async_drop: got req=%b hit=%b expected 0/0", bus.mem_req, bus.d_hit);
        end
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.d_hit !== 1'b0) begin
            miscompares++; $display("FAIL rst_post_miss: got d_hit=%b expected 0", bus.d_hit);
        end
        tick();
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 14'h0023}) begin
            miscompares++;
            $display("FAIL rst_new_fill: got req=%b we=%b addr=%h expected 1/0/0023",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_rdata = 64'h0D0D_0C0C_0B0B_0A0A; bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        vectors++;
        if ({bus.d_hit, bus.rd_data} !== {1'b1, 16'h0A0A}) begin
            miscompares++;
            $display("FAIL rst_refill_hit: got hit=%b rd=%h expected 1/0a0a", bus.d_hit, bus.rd_data);
        end
        bus.Mem_re = 1'b0;
        tick();
    endtask

    task automatic test_withdrawn();
        bus.Mem_re = 1'b1; bus.d_addr = 16'h0252;
        tick();
        bus.Mem_re = 1'b0; bus.d_addr = 16'h0000;
        tick();
        vectors++;
        if ({bus.d_hit, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 14'h0094}) begin
            miscompares++;
            $display("FAIL wd_fill_held: got hit=%b req=%b addr=%h expected 0/1/0094",
                     bus.d_hit, bus.mem_req, bus.mem_addr);
        end
        bus.mem_rdata = 64'h9999_5A5A_7E7E_0F0F; bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        vectors++;
        if ({bus.d_hit, bus.mem_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL wd_idle: got hit=%b req=%b expected 0/0", bus.d_hit, bus.mem_req);
        end
        tick();
        bus.Mem_re = 1'b1; bus.d_addr = 16'h0252;
        #1;
        vectors++;
        if ({bus.d_hit, bus.rd_data, bus.mem_req} !== {1'b1, 16'h5A5A, 1'b0}) begin
            miscompares++;
            $display("FAIL wd_later_hit: got hit=%b rd=%h req=%b expected 1/5a5a/0",
                     bus.d_hit, bus.rd_data, bus.mem_req);
        end
        tick();
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++; $display("FAIL wd_no_req: got req=%b expected 0", bus.mem_req);
        end
        bus.Mem_re = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_zero_wait();
        test_reset_mid_fill();
        test_withdrawn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
